// File: rtl/ub_multibank_stream.sv
// Multi-bank unified buffer: banked single-port storage with independent
// write and read burst engines and a 2-entry read output FIFO.
module ub_multibank_stream #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned CNT_WIDTH  = 9,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_cmd_valid,
  output logic                          rd_cmd_ready,
  input  logic [BANK_BITS+ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [CNT_WIDTH-1:0]          rd_cmd_count,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          rd_last,
  input  logic                          wr_cmd_valid,
  output logic                          wr_cmd_ready,
  input  logic [BANK_BITS+ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [CNT_WIDTH-1:0]          wr_cmd_count,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [STRB_WIDTH-1:0]         wr_strb,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          rd_done,
  output logic                          wr_done,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  typedef enum logic [1:0] {WrIdle, WrData, WrDone} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdIssue, RdDrain} rd_state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  wr_state_e             wr_state_q, wr_state_d;
  logic [BANK_BITS-1:0]  wr_bank_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [CNT_WIDTH-1:0]  wr_left_q;

  rd_state_e             rd_state_q, rd_state_d;
  logic [BANK_BITS-1:0]  rd_bank_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [CNT_WIDTH-1:0]  rd_left_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  fifo_wptr_q, fifo_rptr_q;
  logic [1:0]            fifo_cnt_q;
  logic [15:0]           stall_cnt_q;

  logic wr_fire, wr_cmd_fire, rd_cmd_fire, rd_pop, rd_credit, bank_clash, rd_issue, rd_conflict;

  assign wr_fire     = wr_valid && wr_ready;
  assign wr_cmd_fire = wr_cmd_valid && wr_cmd_ready;
  assign rd_cmd_fire = rd_cmd_valid && rd_cmd_ready;
  assign rd_pop      = rd_valid && rd_ready;
  // A slot freed by this cycle's pop may be refilled in the same cycle.
  assign rd_credit   = (fifo_cnt_q != 2'd2) || rd_pop;
  assign bank_clash  = wr_fire && (wr_bank_q == rd_bank_q);
  assign rd_issue    = (rd_state_q == RdIssue) && rd_credit && !bank_clash;
  assign rd_conflict = (rd_state_q == RdIssue) && rd_credit && bank_clash;

  // Write engine next-state and handshake outputs.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_cmd_ready = 1'b0;
    wr_ready     = 1'b0;
    wr_done      = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        wr_cmd_ready = 1'b1;
        if (wr_cmd_valid) wr_state_d = (wr_cmd_count == '0) ? WrDone : WrData;
      end
      WrData: begin
        wr_ready = 1'b1;
        if (wr_fire && wr_left_q == CntOne) wr_state_d = WrDone;
      end
      WrDone: begin
        wr_done    = 1'b1;
        wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Read engine next-state and handshake outputs.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cmd_ready = 1'b0;
    rd_done      = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        rd_cmd_ready = 1'b1;
        if (rd_cmd_valid) rd_state_d = (rd_cmd_count == '0) ? RdDrain : RdIssue;
      end
      RdIssue: begin
        if (rd_issue && rd_left_q == CntOne) rd_state_d = RdDrain;
      end
      RdDrain: begin
        if (fifo_cnt_q == 2'd0) begin
          rd_done    = 1'b1;
          rd_state_d = RdIdle;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Engine state, burst pointers, FIFO pointers and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WrIdle;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      wr_left_q   <= '0;
      rd_state_q  <= RdIdle;
      rd_bank_q   <= '0;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      if (wr_cmd_fire) begin
        wr_bank_q <= wr_cmd_addr[ADDR_WIDTH +: BANK_BITS];
        wr_addr_q <= wr_cmd_addr[ADDR_WIDTH-1:0];
        wr_left_q <= wr_cmd_count;
      end else if (wr_fire) begin
        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);  // wraps inside the bank
        wr_left_q <= wr_left_q - CntOne;
      end
      if (rd_cmd_fire) begin
        rd_bank_q <= rd_cmd_addr[ADDR_WIDTH +: BANK_BITS];
        rd_addr_q <= rd_cmd_addr[ADDR_WIDTH-1:0];
        rd_left_q <= rd_cmd_count;
      end else if (rd_issue) begin
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        rd_left_q <= rd_left_q - CntOne;
      end
      if (rd_issue) fifo_wptr_q <= ~fifo_wptr_q;
      if (rd_pop)   fifo_rptr_q <= ~fifo_rptr_q;
      if (rd_issue && !rd_pop)      fifo_cnt_q <= fifo_cnt_q + 2'd1;
      else if (!rd_issue && rd_pop) fifo_cnt_q <= fifo_cnt_q - 2'd1;
      if (rd_conflict && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Bank writes with byte strobes; the synchronous bank read lands directly in the FIFO slot.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wr_strb[i]) mem[wr_bank_q][wr_addr_q][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_issue) begin
      fifo_data_q[fifo_wptr_q] <= mem[rd_bank_q][rd_addr_q];
      fifo_last_q[fifo_wptr_q] <= (rd_left_q == CntOne);
    end
  end

  // Output stage; data is masked when empty so reset leaves the bus at zero.
  always_comb begin
    rd_valid = (fifo_cnt_q != 2'd0);
    rd_data  = rd_valid ? fifo_data_q[fifo_rptr_q] : '0;
    rd_last  = rd_valid ? fifo_last_q[fifo_rptr_q] : 1'b0;
  end

  assign busy      = (wr_state_q != WrIdle) || (rd_state_q != RdIdle) || (fifo_cnt_q != 2'd0);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ub_multibank_stream.sv
// Randomized self-checking bench for ub_multibank_stream against an array memory model.
module tb_ub_multibank_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_cmd_valid, rd_cmd_ready, rd_valid, rd_ready, rd_last;
  logic [8:0]   rd_cmd_addr, rd_cmd_count;
  logic [255:0] rd_data;
  logic         wr_cmd_valid, wr_cmd_ready, wr_valid, wr_ready;
  logic [8:0]   wr_cmd_addr, wr_cmd_count;
  logic [255:0] wr_data;
  logic [31:0]  wr_strb;
  logic         rd_done, wr_done, busy;
  logic [15:0]  stall_cnt;

  logic [255:0] mem_m [4][128];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ub_multibank_stream dut (
    .clk(clk), .rst(rst),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_count(rd_cmd_count), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_count(wr_cmd_count), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_done(rd_done),
    .wr_done(wr_done), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic write_burst(input int bank, input int addr, input int cnt, input bit rnd,
                             input logic [255:0] base, input logic [31:0] strb);
    int k, budget, acc_cyc, done_cyc, done_n;
    bit fire;
    logic [255:0] d;
    logic [31:0] s;
    wr_cmd_valid = 1'b1;
    wr_cmd_addr  = {bank[1:0], addr[6:0]};
    wr_cmd_count = cnt[8:0];
    budget = 0; fire = 1'b0; acc_cyc = 0;
    while (!fire && budget < 100) begin
      @(negedge clk); fire = wr_cmd_ready; acc_cyc = cyc;
      @(posedge clk); #1; budget++;
    end
    wr_cmd_valid = 1'b0;
    check_eq("wr_cmd_accept", fire, 1);
    k = 0; done_n = 0; done_cyc = 0; budget = 0;
    while (done_n == 0 && budget < 1000) begin
      wr_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = rnd ? rand256() : base + 256'(k);
      s = rnd ? $urandom : strb;
      wr_data = d; wr_strb = s;
      @(negedge clk);
      fire = wr_valid && wr_ready;
      if (wr_done) begin done_n++; done_cyc = cyc; end
      @(posedge clk); #1; budget++;
      if (fire) begin
        for (int i = 0; i < 32; i++)
          if (s[i]) mem_m[bank][(addr + k) % 128][i*8 +: 8] = d[i*8 +: 8];
        k++;
      end
    end
    wr_valid = 1'b0;
    check_eq("wr_beats", k, cnt);
    check_eq("wr_done_seen", done_n, 1);
    if (cnt == 0) check_eq("wr_done_zero_latency", done_cyc, acc_cyc + 1);
    @(negedge clk);
    check_eq("wr_done_single", wr_done, 0);
    @(posedge clk); #1;
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready pattern 1,0,0 repeating.
  task automatic read_burst(input int bank, input int addr, input int cnt, input int rmode);
    int k, budget, acc_cyc, done_cyc, done_n, first_cyc, phase;
    bit fire, stalled;
    logic [255:0] held_d, exp;
    logic held_l;
    logic [15:0] stall0;
    stall0 = stall_cnt;
    rd_cmd_valid = 1'b1;
    rd_cmd_addr  = {bank[1:0], addr[6:0]};
    rd_cmd_count = cnt[8:0];
    budget = 0; fire = 1'b0; acc_cyc = 0;
    while (!fire && budget < 100) begin
      @(negedge clk); fire = rd_cmd_ready; acc_cyc = cyc;
      @(posedge clk); #1; budget++;
    end
    rd_cmd_valid = 1'b0;
    check_eq("rd_cmd_accept", fire, 1);
    k = 0; done_n = 0; done_cyc = 0; first_cyc = -1; phase = 0; budget = 0;
    stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (done_n == 0 && budget < 1000) begin
      rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (phase % 3 == 0);
      @(negedge clk);
      if (stalled) begin
        check_eq("rd_hold_valid", rd_valid, 1);
        check_eq("rd_hold_data", rd_data, held_d);
        check_eq("rd_hold_last", rd_last, held_l);
      end
      if (rd_valid && first_cyc < 0) first_cyc = cyc;
      if (rd_valid && rd_ready) begin
        exp = mem_m[bank][(addr + k) % 128];
        check_eq("rd_data", rd_data, exp);
        check_eq("rd_last", rd_last, (k == cnt - 1));
        k++;
      end
      stalled = rd_valid && !rd_ready;
      held_d = rd_data; held_l = rd_last;
      if (rd_done) begin done_n++; done_cyc = cyc; end
      @(posedge clk); #1; budget++; phase++;
    end
    rd_ready = 1'b0;
    check_eq("rd_beats", k, cnt);
    check_eq("rd_done_seen", done_n, 1);
    if (cnt == 0) check_eq("rd_done_zero_latency", done_cyc, acc_cyc + 1);
    if (cnt > 0 && rmode == 0 && stall_cnt == stall0)
      check_eq("rd_first_latency", first_cyc, acc_cyc + 2);
    @(negedge clk);
    check_eq("rd_done_single", rd_done, 0);
    check_eq("rd_valid_after", rd_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_cmd_ready"}, rd_cmd_ready, 1);
    check_eq({tag, "_wr_cmd_ready"}, wr_cmd_ready, 1);
    check_eq({tag, "_rd_valid"}, rd_valid, 0);
    check_eq({tag, "_rd_data"}, rd_data, 0);
    check_eq({tag, "_wr_ready"}, wr_ready, 0);
    check_eq({tag, "_done"}, {rd_done, wr_done, rd_last}, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    logic [15:0] s0;
    logic [255:0] d;
    int nf, budget;
    bit fire;
    rst = 1'b1;
    rd_cmd_valid = 1'b0; rd_cmd_addr = '0; rd_cmd_count = '0; rd_ready = 1'b0;
    wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_count = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill every bank so the model is fully known.
    for (int b = 0; b < 4; b++) write_burst(b, 0, 128, 1'b0, rand256(), '1);

    // Basic burst write then read-back.
    write_burst(2, 5, 4, 1'b0, 256'hA0, '1);
    read_burst(2, 5, 4, 0);

    // Byte strobes.
    write_burst(0, 16, 1, 1'b0, '1, '1);
    write_burst(0, 16, 1, 1'b0, '0, 32'h0000_000F);
    check_eq("strb_model", mem_m[0][16], {{28{8'hFF}}, 32'h0});
    read_burst(0, 16, 1, 0);

    // Wrap inside bank 1; bank 2 must be untouched.
    read_burst(1, 126, 4, 0);
    read_burst(2, 0, 8, 0);

    // Same-bank concurrency: every write beat steals a read issue slot.
    s0 = stall_cnt;
    fork
      write_burst(3, 64, 8, 1'b0, rand256(), '1);
      read_burst(3, 64, 8, 0);
    join
    check_eq("stall_same_bank", stall_cnt - s0, 8);
    s0 = stall_cnt;
    fork
      write_burst(0, 40, 8, 1'b0, rand256(), '1);
      read_burst(3, 64, 8, 0);
    join
    check_eq("stall_diff_bank", stall_cnt, s0);

    // Backpressure pattern.
    read_burst(2, 100, 6, 2);

    // Zero-length commands.
    write_burst(1, 10, 0, 1'b0, '0, '1);
    read_burst(1, 10, 0, 0);

    // Randomized bursts.
    for (int it = 0; it < 20; it++) begin
      int b, a, c;
      b = $urandom_range(0, 3); a = $urandom_range(0, 127); c = $urandom_range(0, 12);
      write_burst(b, a, c, 1'b1, '0, '0);
      read_burst(b, (a + 128 - 2) % 128, c + 4, 1);
      read_burst($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(1, 10), 0);
    end

    // Reset mid write-burst after two beats.
    wr_cmd_valid = 1'b1; wr_cmd_addr = {2'd1, 7'h20}; wr_cmd_count = 9'd5;
    @(negedge clk); fire = wr_cmd_ready;
    @(posedge clk); #1;
    wr_cmd_valid = 1'b0;
    check_eq("rst_wr_accept", fire, 1);
    nf = 0; budget = 0;
    while (nf < 2 && budget < 50) begin
      d = rand256();
      wr_data = d; wr_strb = '1; wr_valid = 1'b1;
      @(negedge clk); fire = wr_ready;
      @(posedge clk); #1; budget++;
      if (fire) begin mem_m[1][32 + nf] = d; nf++; end
    end
    check_eq("rst_two_beats", nf, 2);
    check_eq("rst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    read_burst(1, 32, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
